// File: rtl/updown_count_monitor.sv
// updown_count_monitor
//
// Watches the value of an external up/down counter and classifies each
// enabled sample against the previous one: hold, up by one, down by one,
// or an illegal jump. It reports wrap-around steps, keeps a sticky error
// flag and counts consecutive steps in the same direction.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset, dominates all other inputs
//   en         in   sample enable; count_in is only looked at when en=1
//   count_in   in   [WIDTH-1:0] observed counter value
//   clr_err    in   clears the sticky err flag (an illegal step on the same edge wins)
//   valid      out  at least one sample taken since reset
//   dir        out  [1:0] last classified step: 00 hold, 01 up, 10 down, 11 illegal
//   wrap_up    out  one-cycle pulse on an up step from all-ones to zero
//   wrap_down  out  one-cycle pulse on a down step from zero to all-ones
//   err        out  sticky illegal-step flag
//   run_len    out  [WIDTH-1:0] consecutive same-direction steps, saturating
//   dbg_state  out  [2:0] FSM state (EMPTY=0, HOLD=1, UP=2, DOWN=3, ERR=4)
//
// Handshake: there is no flow control. Every rising edge with en=1 is one
// sample; all outputs are registered and show the result of that sample
// right after the edge that took it.

module updown_count_monitor #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clr_err,
  output logic             valid,
  output logic [1:0]       dir,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic             err,
  output logic [WIDTH-1:0] run_len,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_HOLD  = 3'd1,
    S_UP    = 3'd2,
    S_DOWN  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    LS_NONE = 2'd0,
    LS_UP   = 2'd1,
    LS_DOWN = 2'd2
  } last_step_e;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAXV = '1;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_ILL  = 2'b11;

  state_e           state_q, state_d;
  last_step_e       last_q, last_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             valid_q, valid_d;
  logic [1:0]       dir_q, dir_d;
  logic             wrap_up_q, wrap_up_d;
  logic             wrap_down_q, wrap_down_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] run_q, run_d;
  logic [WIDTH-1:0] delta;

  // Modular difference; the subtraction wraps naturally at WIDTH bits.
  assign delta = count_in - prev_q;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    prev_d      = prev_q;
    valid_d     = valid_q;
    dir_d       = dir_q;
    run_d       = run_q;
    // Wrap flags are pulses: cleared on every edge unless a wrap happens.
    wrap_up_d   = 1'b0;
    wrap_down_d = 1'b0;
    // clr_err acts even with en=0; an illegal step below overrides it.
    err_d       = clr_err ? 1'b0 : err_q;

    if (en) begin
      if (state_q == S_EMPTY) begin
        // First sample only establishes the reference value.
        prev_d  = count_in;
        valid_d = 1'b1;
        dir_d   = DIR_HOLD;
        state_d = S_HOLD;
      end else begin
        prev_d = count_in;
        if (delta == ZERO) begin
          // Hold leaves run_len and last_step untouched.
          dir_d   = DIR_HOLD;
          state_d = S_HOLD;
        end else if (delta == ONE) begin
          dir_d     = DIR_UP;
          state_d   = S_UP;
          run_d     = (last_q != LS_UP) ? ONE :
                      (run_q == MAXV)   ? MAXV : run_q + ONE;
          last_d    = LS_UP;
          wrap_up_d = (prev_q == MAXV);
        end else if (delta == MAXV) begin
          dir_d       = DIR_DOWN;
          state_d     = S_DOWN;
          run_d       = (last_q != LS_DOWN) ? ONE :
                        (run_q == MAXV)     ? MAXV : run_q + ONE;
          last_d      = LS_DOWN;
          wrap_down_d = (prev_q == ZERO);
        end else begin
          dir_d   = DIR_ILL;
          state_d = S_ERR;
          run_d   = ZERO;
          last_d  = LS_NONE;
          err_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      last_q      <= LS_NONE;
      prev_q      <= ZERO;
      valid_q     <= 1'b0;
      dir_q       <= DIR_HOLD;
      wrap_up_q   <= 1'b0;
      wrap_down_q <= 1'b0;
      err_q       <= 1'b0;
      run_q       <= ZERO;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      prev_q      <= prev_d;
      valid_q     <= valid_d;
      dir_q       <= dir_d;
      wrap_up_q   <= wrap_up_d;
      wrap_down_q <= wrap_down_d;
      err_q       <= err_d;
      run_q       <= run_d;
    end
  end

  assign valid     = valid_q;
  assign dir       = dir_q;
  assign wrap_up   = wrap_up_q;
  assign wrap_down = wrap_down_q;
  assign err       = err_q;
  assign run_len   = run_q;
  assign dbg_state = state_q;

endmodule

// File: doc/updown_count_monitor.md
UPDOWN_COUNT_MONITOR -- requirements
Module: updown_count_monitor

Interface
REQ-001 Parameter WIDTH, default 5, SHALL be the bit width of the observed count; all modular arithmetic SHALL be mod 2^WIDTH.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 en  input  1  SHALL be the sample enable; count_in is evaluated only on edges where en=1.
REQ-005 count_in  input  WIDTH  SHALL carry the up/down counter value under observation.
REQ-006 clr_err  input  1  SHALL clear the sticky error flag.
REQ-007 valid  output  1  SHALL be high once at least one sample has been taken since reset.
REQ-008 dir  output  2  SHALL give the last classified step: 00 hold, 01 up, 10 down, 11 illegal.
REQ-009 wrap_up  output  1  SHALL pulse for one cycle on an up step from 2^WIDTH-1 to 0.
REQ-010 wrap_down  output  1  SHALL pulse for one cycle on a down step from 0 to 2^WIDTH-1.
REQ-011 err  output  1  SHALL be a sticky illegal-step flag.
REQ-012 run_len  output  WIDTH  SHALL count consecutive same-direction steps, saturating at 2^WIDTH-1.

Function
REQ-013 The block SHALL hold an internal register prev and an FSM with states EMPTY, HOLD, UP, DOWN, ERR.
REQ-014 All outputs SHALL be registered and SHALL reflect a sample on the same rising edge at which it is taken (1-cycle latency from count_in to outputs).
REQ-015 In EMPTY with en=1, the block SHALL load prev<=count_in, set valid=1, go to HOLD, keep dir=00, and SHALL NOT classify a step.
REQ-016 In any non-EMPTY state with en=1, the block SHALL compute delta=(count_in-prev) mod 2^WIDTH and SHALL then set prev<=count_in.
REQ-017 Classification: delta 0 -> dir=00, state HOLD; delta 1 -> dir=01, state UP; delta 2^WIDTH-1 -> dir=10, state DOWN; any other delta -> dir=11, state ERR.
REQ-018 wrap_up SHALL be 1 only for an up step with prev=2^WIDTH-1 and count_in=0; wrap_down SHALL be 1 only for a down step with prev=0 and count_in=2^WIDTH-1; both SHALL be 0 on every other edge, including every edge with en=0.
REQ-019 An internal last_step register (none/up/down) SHALL record the direction of the most recent up or down step.
REQ-020 On an up or down step, run_len SHALL increment (saturating at 2^WIDTH-1) if the step matches last_step, and SHALL load 1 otherwise.
REQ-021 A hold step SHALL leave run_len and last_step unchanged.
REQ-022 An illegal step SHALL set run_len=0, set last_step=none, and set err=1.
REQ-023 ERR SHALL be left on the next legal step, following REQ-017; err SHALL remain 1 regardless.
REQ-024 clr_err=1 SHALL clear err on that edge, unless the same edge classifies an illegal step, in which case err SHALL be 1.
REQ-025 With en=0, the FSM, prev, dir, run_len and valid SHALL hold their values; clr_err SHALL still act.

Reset
REQ-026 reset=1 SHALL set: state EMPTY, prev=0, last_step=none, valid=0, dir=00, wrap_up=0, wrap_down=0, err=0, run_len=0.
REQ-027 reset SHALL dominate en and clr_err, and SHALL take effect from any state, including mid-run and in ERR.
REQ-028 The first sample after reset SHALL follow REQ-015 and SHALL never flag a step or wrap.

Verification
REQ-029 Reset, then en=1 with count_in 3,4,5,6 -> valid=1 after the first edge; dir=01 after 4; run_len 1,2,3; err=0.
REQ-030 count_in 30,31,0,1 (up) -> wrap_up=1 for exactly the cycle after 0 is sampled; run_len=3; wrap_down=0 throughout.
REQ-031 count_in 2,1,0,31,30 -> dir=10; wrap_down pulses once (after 31 is sampled); run_len=4.
REQ-032 count_in 5,6,6,7 -> after the second 6, dir=00 and run_len=1 is held; after 7, dir=01 and run_len=2.
REQ-033 count_in 5,9 -> dir=11, err=1, run_len=0; then 10 -> dir=01, run_len=1, err still 1; then clr_err=1 -> err=0; clr_err=1 coincident with 10 -> 20 -> err=1.
REQ-034 reset=1 asserted mid-up-run (run_len=4) with en=1 -> all outputs take REQ-026 values on that edge; the next sample, e.g. 17, gives valid=1, dir=00, no wrap.
